// File: rtl/cpu_defs.sv
// cpu_defs: shared write-back/load codes and MEM/WB pipeline record
package cpu_defs;
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC8 = 2'd2;
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [31:0] RESET_PC8 = 32'h0000_3008;
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc8;
  } mw_t;
endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// load_ext: little-endian sub-word select and sign/zero extension of a loaded word
module load_ext
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b   = rdata[{addr, 3'b000} +: 8];
    h   = addr[1] ? rdata[31:16] : rdata[15:0];
    ext = load_type == LD_LB  ? {{24{b[7]}}, b} :
          load_type == LD_LBU ? {24'b0, b} :
          load_type == LD_LH  ? {{16{h[15]}}, h} :
          load_type == LD_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load extension and write-back mux
module mem_wb_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC8_P = RESET_PC8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic [4:0]  write_reg_m,
  input  logic [1:0]  wb_sel_m,
  input  logic [2:0]  load_type_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] mem_rdata_m,
  input  logic [31:0] pc8_m,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write,
  output logic [31:0] pc8_w,
  output logic        fwd_valid_w,
  output logic [4:0]  fwd_reg_w,
  output logic [31:0] fwd_data_w
);
  mw_t r;
  logic [31:0] load_val, wb_val;
  always_ff @(posedge clk) begin
    if (reset) begin
      r     <= '0;
      r.pc8 <= RESET_PC8_P;
    end else begin
      r <= '{valid_m, reg_write_m, write_reg_m, wb_sel_m, load_type_m,
             alu_result_m, mem_rdata_m, pc8_m};
    end
  end
  load_ext u_load_ext (
    .rdata    (r.mem_rdata),
    .addr     (r.alu_result[1:0]),
    .load_type(r.load_type),
    .ext      (load_val)
  );
  always_comb begin
    wb_val      = r.wb_sel == WB_SEL_MEM ? load_val :
                  r.wb_sel == WB_SEL_PC8 ? r.pc8 : r.alu_result;
    reg_write   = r.valid & r.reg_write;
    write_reg   = r.write_reg;
    write_data  = reg_write ? wb_val : 32'b0;
    pc8_w       = r.pc8;
    fwd_valid_w = reg_write & (r.write_reg != 5'd0);
    fwd_reg_w   = r.write_reg;
    fwd_data_w  = write_data;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register plus write-back logic of the 5-stage MIPS core. Captures MEM-stage results each cycle, extends the raw data-memory word for sub-word loads, selects the write-back source and drives the register file's write port (writereg, writedata, RegWrite, PC8). It also exports the W-stage forwarding tuple to the hazard/forwarding unit.

Parameters:
RESET_PC8, 32'h0000_3008, value loaded into pc8_w on reset; reset PC 0x3000 + 8.

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high
valid_m  in  1  MEM slot holds a real instruction (0 = bubble)
reg_write_m  in  1  instruction writes a GPR
write_reg_m  in  5  destination GPR number
wb_sel_m  in  2  write-back source: 0 ALU, 1 MEM load, 2 PC8, 3 reserved
load_type_m  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5-7 reserved
alu_result_m  in  32  ALU result / effective address
mem_rdata_m  in  32  raw aligned word read from data memory
pc8_m  in  32  PC+8 of the MEM instruction
write_reg  out  5  to rf writereg
write_data  out  32  to rf writedata
reg_write  out  1  to rf RegWrite
pc8_w  out  32  to rf PC8
fwd_valid_w  out  1  W-stage result is forwardable
fwd_reg_w  out  5  W-stage destination for forwarding compare
fwd_data_w  out  32  W-stage value for forwarding

Behaviour:
- Reset (reset=1 at posedge): all pipeline fields cleared; valid=0, reg_write=0, write_reg=0, write_data=0, fwd_valid_w=0, fwd_reg_w=0, fwd_data_w=0, pc8_w=RESET_PC8. Reset overrides any capture in the same cycle.
- No enable/stall: every non-reset posedge captures all *_m inputs. The core never stalls or flushes M/W; bubbles arrive as valid_m=0.
- Latency: MEM inputs at edge N are visible on outputs after edge N; rf commits them at edge N+1.
- Write-back data is combinational from registered fields (extension happens in W, not M):
  - wb_sel 0 -> alu_result; 2 -> pc8; 3 -> alu_result.
  - wb_sel 1 -> load extension. Byte select uses addr[1:0] = alu_result[1:0], little-endian: byte k = rdata[8k+7:8k]. Halfword select uses addr[1]: 0 -> rdata[15:0], 1 -> rdata[31:16]. addr[0] is ignored for halfwords; addr[1:0] is ignored for LW.
  - LB/LH sign-extend; LBU/LHU zero-extend; reserved load_type behaves as LW.
- reg_write = valid & reg_write_field. Writes to $0 pass through unchanged; rf discards them.
- write_data is forced to 0 when reg_write=0, giving deterministic waveforms.
- fwd_valid_w = reg_write & (write_reg != 0). fwd_reg_w = write_reg. fwd_data_w = write_data.
- Bubble: valid_m=0 captured -> reg_write=0, fwd_valid_w=0. Other fields are still captured; the write is inhibited by reg_write=0.
- Reset mid-stream: an instruction captured in the reset cycle is discarded and never reaches rf.

Decomposition:
- Shared package/header (cpu_defs): WB_SEL_ALU/MEM/PC8 codes, LD_LW/LB/LBU/LH/LHU codes, RESET_PC8 constant; used by the control decoder and this block.
- One sub-module: load_ext, purely combinational: (rdata, addr[1:0], load_type) -> 32-bit extended value.
- The pipeline register and mux stay in mem_wb_stage.

Test Plan:
- LB, rdata=0x1280_FF34, addr=0x...1 -> write_data=0xFFFF_FFFF. Same with addr=2 -> 0xFFFF_FF80.
- LBU addr=3, rdata=0x9A00_0000 -> 0x0000_009A. LHU addr=2, rdata=0x8001_7FFF -> 0x0000_8001. LH addr=2, same rdata -> 0xFFFF_8001.
- JAL: wb_sel=2, pc8_m=0x0000_3010, write_reg_m=31, reg_write_m=1 -> next cycle write_reg=31, write_data=0x0000_3010, reg_write=1, fwd_valid_w=1.
- $0 write: write_reg_m=0, reg_write_m=1 -> reg_write=1, fwd_valid_w=0. A following bubble (valid_m=0) -> reg_write=0, write_data=0.
- Back-to-back: ALU 0x1234 to $8, then LW 0xDEAD_BEEF to $9 on consecutive cycles -> outputs change on each edge with no dropped or duplicated write.
- Reset asserted while an ALU write to $5 is captured -> outputs are reset values (pc8_w=0x0000_3008, reg_write=0) and the $5 write never appears. Deassert -> normal capture resumes the next edge.
